icache_fill: RTL and testbench
==============================

ICACHE_FILL -- requirements
Module: icache_fill

Interface
REQ-001 Parameter: NUM_LINES, default 4, number of direct-mapped lines (power of two, >=2); line width is ICLLEN (128) bits from constants_pkg.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req_valid  input  1  core requests an instruction fetch this cycle.
REQ-005 req_addr  input  32  byte fetch address; bits [1:0] ignored.
REQ-006 flush  input  1  invalidate all lines.
REQ-007 rsp_valid  output  1  rsp_instr holds the requested instruction this cycle.
REQ-008 rsp_instr  output  32  fetched instruction word.
REQ-009 stall  output  1  miss in progress; core holds its request.
REQ-010 bus  data_bus.consumer  --  requester end of the data bus: drives ldp (1) and ldAddr (32); receives ldr (1) and ldData (ICLLEN).
REQ-011 hit_count, miss_count  output  32 each  performance counters (see Configuration).

Function
REQ-012 Address split: offset = req_addr[3:0], word select = req_addr[3:2], index = next log2(NUM_LINES) bits, tag = remaining upper bits.
REQ-013 Storage per line: valid bit, tag, ICLLEN data bits; word k of a line = data[32k+31:32k] (word 0 = bits [31:0]).
REQ-014 FSM states: IDLE, FILL.
REQ-015 IDLE, req_valid, line valid and tag match (hit): rsp_valid=1 and rsp_instr=selected word combinationally in the same cycle; stall=0; stay IDLE.
REQ-016 IDLE, req_valid and miss: rsp_valid=0, stall=1; latch req_addr into miss_addr; next state FILL.
REQ-017 FILL: stall=1, rsp_valid=0; bus.ldp=1 while bus.ldr=0; bus.ldAddr={miss_addr[31:4],4'b0} held constant.
REQ-018 FILL with bus.ldr=1: bus.ldp=0 in that cycle; at the clock edge write bus.ldData, miss_addr tag and valid=1 into the indexed line; next state IDLE.
REQ-019 The refilled request hits in IDLE the cycle after the fill; miss-to-rsp_valid latency against a memory answering one cycle after ldp = 3 cycles (rsp_valid in cycle 3 when the miss is in cycle 0).
REQ-020 bus.ldp=0 and bus.ldAddr=0 in IDLE; at most one outstanding bus request.
REQ-021 req_valid=0 in IDLE: rsp_valid=0, stall=0, no state change.
REQ-022 A new index with a different tag overwrites the resident line (no replacement choice).
REQ-023 flush: all valid bits cleared at the clock edge; if flush and bus.ldr coincide in FILL, the fill write is dropped (line stays invalid) and FSM goes IDLE.
REQ-024 flush in FILL without ldr: valids cleared, FSM stays FILL, later fill completes normally.
REQ-025 flush in IDLE with req_valid: lookup uses pre-flush valids this cycle.
REQ-026 rsp_instr = 0 whenever rsp_valid=0.

Reset
REQ-027 rst=1 at a clock edge: state=IDLE, all valid bits=0, miss_addr=0, counters=0; tag/data arrays need not reset.
REQ-028 Reset during FILL aborts the fill: bus.ldp=0 from the next cycle; a late ldr is ignored.
REQ-029 Outputs after reset: rsp_valid=0, rsp_instr=0, stall=0, bus.ldp=0, bus.ldAddr=0.

Configuration
REQ-030 Macro ICACHE_PERF_CNT_EN: defined -> hit_count increments per IDLE hit cycle, miss_count per IDLE miss cycle, both saturating at 32'hFFFFFFFF; undefined -> no counter registers, both outputs tied to 0.

Verification
REQ-031 Reset, req 0x00 -> cycle0 stall=1; cycle1 ldp=1, ldAddr=0x00; memory ldr with 128'hfe1088e3_0040a103_0010a223_40010093 in cycle2; cycle3 rsp_valid=1, rsp_instr=0x40010093.
REQ-032 Following req 0x08 then 0x0C -> immediate hits, rsp_instr 0x0040a103 then 0xfe1088e3, ldp stays 0.
REQ-033 Req 0x40 (NUM_LINES=4, same index 0) -> miss, ldAddr=0x40; subsequent req 0x00 misses again.
REQ-034 flush in IDLE, then req 0x04 -> miss with ldAddr=0x00; flush coincident with ldr -> following req to same line misses again.
REQ-035 rst asserted in FILL before ldr -> next cycle ldp=0, stall=0; ldr pulse afterwards leaves all lines invalid.
REQ-036 With ICACHE_PERF_CNT_EN: scenarios REQ-031..032 -> hit_count=3, miss_count=1; without macro both read 0.

Source files
------------

// File: rtl/constants_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : constants_pkg
//  Description : Shared constants for the instruction-fetch path.
//                ICLLEN - instruction cache line width in bits.
//  Revision    : 1.0  initial release
// ============================================================================
package constants_pkg;
  localparam int ICLLEN = 128;
endpackage
`default_nettype wire

// File: rtl/icache_fill_if.sv
`default_nettype none
// ============================================================================
//  Interface   : data_bus
//  Description : Line-load bus between the instruction cache and memory.
//                ldp    - load request pending (requester -> memory)
//                ldAddr - line-aligned load address (requester -> memory)
//                ldr    - load data ready, one-cycle strobe (memory -> requester)
//                ldData - full line of ICLLEN bits (memory -> requester)
//                consumer/master: requester end; producer/slave: memory end.
//  Revision    : 1.0  initial release
// ============================================================================
interface data_bus
  import constants_pkg::*;
  ();
  logic              ldp;
  logic [31:0]       ldAddr;
  logic              ldr;
  logic [ICLLEN-1:0] ldData;

  modport consumer (output ldp, output ldAddr, input ldr, input ldData);
  modport producer (input ldp, input ldAddr, output ldr, output ldData);
  modport master   (output ldp, output ldAddr, input ldr, input ldData);
  modport slave    (input ldp, input ldAddr, output ldr, output ldData);
endinterface
`default_nettype wire

// File: rtl/icache_fill.sv
`default_nettype none
// ============================================================================
//  Module      : icache_fill
//  Description : Direct-mapped instruction cache with single-line refill.
//                Hits answer combinationally in the request cycle; a miss
//                stalls the core, loads the whole line over data_bus and the
//                retried request then hits.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                req_valid/req_addr - fetch request (addr bits [1:0] ignored)
//                flush              - invalidate all lines
//                rsp_valid/rsp_instr- fetched word (instr is 0 when not valid)
//                stall              - miss in progress
//                bus                - data_bus.consumer line-load port
//                hit_count/miss_count - saturating performance counters
//  Options     : ICACHE_PERF_CNT_EN - when defined, counters are implemented;
//                otherwise both counter outputs are tied to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module icache_fill
  import constants_pkg::*;
#(
  parameter int NUM_LINES = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        req_valid,
  input  wire logic [31:0] req_addr,
  input  wire logic        flush,
  output logic             rsp_valid,
  output logic [31:0]      rsp_instr,
  output logic             stall,
  data_bus.consumer        bus,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
);

  localparam int IDXW = $clog2(NUM_LINES);
  localparam int TAGW = 28 - IDXW;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t                r_state;
  logic [NUM_LINES-1:0]  r_valid;
  logic [TAGW-1:0]       r_tag  [NUM_LINES];
  logic [ICLLEN-1:0]     r_data [NUM_LINES];
  logic [31:0]           r_miss_addr;

  logic [IDXW-1:0]       w_idx;
  logic [TAGW-1:0]       w_tag;
  logic [IDXW-1:0]       w_fill_idx;
  logic [ICLLEN-1:0]     w_line;
  logic                  w_lookup;
  logic                  w_hit;
  logic                  w_miss;
  logic                  w_fill_done;
  logic                  w_unused;

  assign w_idx      = req_addr[4 +: IDXW];
  assign w_tag      = req_addr[31 -: TAGW];
  assign w_fill_idx = r_miss_addr[4 +: IDXW];
  assign w_line     = r_data[w_idx];

  // Lookup only happens in IDLE; flush this cycle does not affect the
  // lookup because r_valid still holds the pre-flush bits.
  assign w_lookup    = (r_state == S_IDLE) && req_valid;
  assign w_hit       = w_lookup && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_miss      = w_lookup && !w_hit;
  assign w_fill_done = (r_state == S_FILL) && bus.ldr;

  assign rsp_valid = w_hit;
  assign rsp_instr = w_hit ? w_line[{req_addr[3:2], 5'b0} +: 32] : 32'd0;
  assign stall     = w_miss || (r_state == S_FILL);

  // Request drops in the same cycle ldr arrives so only one load is ever
  // outstanding; the address is line-aligned and zero outside FILL.
  assign bus.ldp    = (r_state == S_FILL) && !bus.ldr;
  assign bus.ldAddr = (r_state == S_FILL) ? {r_miss_addr[31:4], 4'b0} : 32'd0;

  assign w_unused = &{1'b0, req_addr[1:0], r_miss_addr[3:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_miss_addr <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_miss) begin
            r_miss_addr <= req_addr;
            r_state     <= S_FILL;
          end
        end
        S_FILL: begin
          if (bus.ldr) begin
            r_state <= S_IDLE;
            if (!flush) begin
              r_valid[w_fill_idx] <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Placed last so a flush overrides any valid bit set above.
      if (flush) begin
        r_valid <= '0;
      end
    end
  end

  // Tag/data arrays carry no reset; the valid bits qualify their contents.
  always_ff @(posedge clk) begin
    if (!rst && w_fill_done && !flush) begin
      r_tag[w_fill_idx]  <= r_miss_addr[31 -: TAGW];
      r_data[w_fill_idx] <= bus.ldData;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else begin
      if (w_hit && (r_hit_cnt != 32'hFFFF_FFFF)) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (w_miss && (r_miss_cnt != 32'hFFFF_FFFF)) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_fill.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_fill
//  Description : Scoreboard bench for icache_fill. Fetch stimulus pushes the
//                expected instruction and expected bus load addresses into
//                queues; monitors pop and compare when the DUT presents
//                rsp_valid or raises ldp. A small memory model answers ldp
//                one cycle later with hand-written line contents.
//                Honours ICACHE_PERF_CNT_EN for the counter expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_icache_fill;
  import constants_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        flush;
  logic        rsp_valid;
  logic [31:0] rsp_instr;
  logic        stall;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  data_bus bus_if ();

  icache_fill #(.NUM_LINES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .flush      (flush),
    .rsp_valid  (rsp_valid),
    .rsp_instr  (rsp_instr),
    .stall      (stall),
    .bus        (bus_if),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rsp_q [$];
  logic [31:0] exp_ld_q  [$];
  logic        mem_auto  = 1'b1;
  logic        force_ldr = 1'b0;
  logic        prev_ldp  = 1'b0;

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    case (a)
      32'h00:  return 128'hfe1088e3_0040a103_0010a223_40010093;
      32'h10:  return 128'h1c1c1c1c_18181818_14141414_10101010;
      32'h20:  return 128'h2c2c2c2c_28282828_24242424_20202020;
      32'h40:  return 128'h4c4c4c4c_48484848_44444444_40404040;
      default: return 128'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: sees ldp at the negedge, answers with one ldr cycle after.
  initial begin
    logic        f;
    logic        fl;
    logic [31:0] a;
    bus_if.ldr    = 1'b0;
    bus_if.ldData = '0;
    forever begin
      @(negedge clk);
      f  = mem_auto && bus_if.ldp;
      fl = force_ldr;
      a  = bus_if.ldAddr;
      @(posedge clk);
      #1;
      bus_if.ldr    = f || fl;
      bus_if.ldData = f ? mem_line(a) : (fl ? mem_line(32'h20) : 128'h0);
    end
  end

  // Response and bus monitors.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rsp_valid) begin
          if (exp_rsp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got %h expected none", rsp_instr);
          end else begin
            chk("rsp_instr", rsp_instr, exp_rsp_q.pop_front());
          end
        end else begin
          chk("rsp_instr_zero", rsp_instr, 32'd0);
        end
        if (!stall) begin
          chk("idle_ldp", {31'd0, bus_if.ldp}, 32'd0);
          chk("idle_ldAddr", bus_if.ldAddr, 32'd0);
        end
      end
      if (bus_if.ldp && !prev_ldp) begin
        if (exp_ld_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load: got %h expected none", bus_if.ldAddr);
        end else begin
          chk("ldAddr", bus_if.ldAddr, exp_ld_q.pop_front());
        end
      end
      prev_ldp = bus_if.ldp;
    end
  end

  // Issue one fetch, hold it until rsp_valid, check the latency in cycles.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] instr,
                       input int exp_lat, input int nfill,
                       input logic [31:0] ld_addr, input int flush_at);
    bit got;
    int lat;
    got = 1'b0;
    lat = -1;
    exp_rsp_q.push_back(instr);
    for (int k = 0; k < nfill; k++) exp_ld_q.push_back(ld_addr);
    req_valid = 1'b1;
    req_addr  = addr;
    for (int n = 0; n < 16; n++) begin
      flush = (n == flush_at);
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        lat = n;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: addr %h got no rsp expected %0d cycles", addr, exp_lat);
      exp_rsp_q.delete();
    end else begin
      chk("latency", lat, exp_lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input logic [31:0] h, input logic [31:0] m);
`ifdef ICACHE_PERF_CNT_EN
    chk("hit_count", hit_count, h);
    chk("miss_count", miss_count, m);
`else
    chk("hit_count", hit_count, 32'd0);
    chk("miss_count", miss_count, 32'd0);
    if (h == m) begin end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = 32'd0;
    flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_instr", rsp_instr, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_ldp", {31'd0, bus_if.ldp}, 32'd0);
    chk("rst_ldAddr", bus_if.ldAddr, 32'd0);
    check_counters(32'd0, 32'd0);
    @(posedge clk);
    #1;

    // Cold miss then hits in the same line.
    fetch(32'h00, 32'h40010093, 3, 1, 32'h00, -1);
    fetch(32'h08, 32'h0040a103, 0, 0, 32'h00, -1);
    fetch(32'h0C, 32'hfe1088e3, 0, 0, 32'h00, -1);
    @(negedge clk);
    check_counters(32'd3, 32'd1);
    @(posedge clk);
    #1;

    // Conflicting tag on index 0 evicts, original line misses again.
    fetch(32'h40, 32'h40404040, 3, 1, 32'h40, -1);
    fetch(32'h00, 32'h40010093, 3, 1, 32'h00, -1);

    // Flush in IDLE without a request, then refetch misses.
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    fetch(32'h04, 32'h0010a223, 3, 1, 32'h00, -1);

    // Flush coincident with ldr: the line stays invalid, request refills.
    fetch(32'h44, 32'h44444444, 6, 2, 32'h40, 2);

    // Flush with a hit uses pre-flush valids; next access misses.
    fetch(32'h48, 32'h48484848, 0, 0, 32'h00, 0);
    fetch(32'h4C, 32'h4c4c4c4c, 3, 1, 32'h40, -1);

    // Flush during FILL without ldr: fill still completes and is kept.
    fetch(32'h10, 32'h10101010, 3, 1, 32'h10, 1);
    fetch(32'h14, 32'h14141414, 0, 0, 32'h00, -1);

    // Reset during FILL aborts the load; a late ldr is ignored.
    mem_auto = 1'b0;
    exp_ld_q.push_back(32'h20);
    req_valid = 1'b1;
    req_addr  = 32'h20;
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("fill_ldp", {31'd0, bus_if.ldp}, 32'd1);
    chk("fill_ldAddr", bus_if.ldAddr, 32'h20);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ldp", {31'd0, bus_if.ldp}, 32'd0);
    chk("abort_stall", {31'd0, stall}, 32'd0);
    check_counters(32'd0, 32'd0);
    @(posedge clk);
    #1;
    force_ldr = 1'b1;
    @(posedge clk);
    #1;
    force_ldr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mem_auto = 1'b1;
    fetch(32'h20, 32'h20202020, 3, 1, 32'h20, -1);
    fetch(32'h00, 32'h40010093, 3, 1, 32'h00, -1);
    fetch(32'h10, 32'h10101010, 3, 1, 32'h10, -1);

    chk("rsp_queue_empty", exp_rsp_q.size(), 32'd0);
    chk("load_queue_empty", exp_ld_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
